// File: rtl/commit_unit.sv
// In-order retirement stage: register writeback, committed stores via req/ack, halt on WFI.
// Optional COMMIT_STATS_EN adds retired_count and store_stall_cycles outputs.

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

package commit_unit_pkg;

    localparam int unsigned ENTRY_XLEN = 32;

    typedef struct packed {
        logic                  valid;
        logic [ENTRY_XLEN-1:0] npc;
        logic [31:0]           inst;
        logic                  wr_mem;
        logic [4:0]            dest_reg;
        logic [ENTRY_XLEN-1:0] dest_addr;
        logic [ENTRY_XLEN-1:0] value;
        logic [2:0]            mem_size;
    } rob_entry_t;

endpackage

module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int unsigned XLEN      = ENTRY_XLEN,
    parameter int unsigned TAG_LEN   = `ROB_TAG_LEN,
    parameter logic [31:0] HALT_INST = 32'h10500073
) (
    input  logic               clock,
    input  logic               reset,
    input  rob_entry_t         head_entry,
    input  logic [TAG_LEN-1:0] head,
    input  logic               head_ready,
    output logic               rob_retire,
    output logic               rf_wr_en,
    output logic [4:0]         rf_wr_idx,
    output logic [XLEN-1:0]    rf_wr_data,
    output logic [TAG_LEN-1:0] rf_wr_tag,
    output logic               mem_req,
    output logic [XLEN-1:0]    mem_addr,
    output logic [XLEN-1:0]    mem_data,
    output logic [2:0]         mem_size,
    input  logic               mem_ack,
    output logic [XLEN-1:0]    commit_npc,
    output logic               halt
`ifdef COMMIT_STATS_EN
   ,output logic [31:0]        retired_count,
    output logic [31:0]        store_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STORE,
        S_HALTED
    } state_t;

    state_t             state;
    logic               mem_req_q;
    logic [XLEN-1:0]    st_addr_q;
    logic [XLEN-1:0]    st_data_q;
    logic [XLEN-1:0]    st_npc_q;
    logic [2:0]         st_size_q;
    logic [TAG_LEN-1:0] st_tag_q;
    logic [XLEN-1:0]    commit_npc_q;
    logic               halt_q;

    logic head_go;
    logic is_halt;
    logic idle_retire;
    logic store_start;
    logic store_done;

    always_comb begin
        head_go     = head_entry.valid && head_ready;
        is_halt     = (head_entry.inst == HALT_INST);
        // Gated by reset so every combinational output is 0 while reset is held.
        idle_retire = reset && (state == S_IDLE) && head_go && (is_halt || !head_entry.wr_mem);
        store_start = (state == S_IDLE) && head_go && head_entry.wr_mem && !is_halt;
        store_done  = (state == S_STORE) && mem_ack;
    end

    always_comb begin
        rob_retire = idle_retire || store_done;
        rf_wr_en   = idle_retire && !is_halt && (head_entry.dest_reg != 5'd0);
        rf_wr_idx  = '0;
        rf_wr_data = '0;
        rf_wr_tag  = '0;
        if (rf_wr_en) begin
            rf_wr_idx  = head_entry.dest_reg;
            rf_wr_data = head_entry.value;
            rf_wr_tag  = head;
        end else if (store_done) begin
            rf_wr_tag  = st_tag_q;
        end
        mem_req    = mem_req_q;
        mem_addr   = st_addr_q;
        mem_data   = st_data_q;
        mem_size   = st_size_q;
        commit_npc = commit_npc_q;
        halt       = halt_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            mem_req_q    <= 1'b0;
            st_addr_q    <= '0;
            st_data_q    <= '0;
            st_npc_q     <= '0;
            st_size_q    <= '0;
            st_tag_q     <= '0;
            commit_npc_q <= '0;
            halt_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (idle_retire) begin
                        commit_npc_q <= head_entry.npc;
                        if (is_halt) begin
                            halt_q <= 1'b1;
                            state  <= S_HALTED;
                        end
                    end else if (store_start) begin
                        // NPC is latched too, so head changes during the store cannot leak in.
                        st_addr_q <= head_entry.dest_addr;
                        st_data_q <= head_entry.value;
                        st_size_q <= head_entry.mem_size;
                        st_npc_q  <= head_entry.npc;
                        st_tag_q  <= head;
                        mem_req_q <= 1'b1;
                        state     <= S_STORE;
                    end
                end
                S_STORE: begin
                    if (mem_ack) begin
                        commit_npc_q <= st_npc_q;
                        mem_req_q    <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_IDLE;
            endcase
        end
    end

`ifdef COMMIT_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_count      <= '0;
            store_stall_cycles <= '0;
        end else begin
            if (rob_retire) begin
                retired_count <= retired_count + 32'd1;
            end
            if ((state == S_STORE) && !mem_ack && (store_stall_cycles != '1)) begin
                store_stall_cycles <= store_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- In-order retirement stage; it consumes the ROB head interface (head_entry, head_ready, head tag) and tells the ROB when to advance head via a retire pulse.
- Writes the architectural register file and clears map-table entries.
- Performs committed stores to data memory with a req/ack handshake.
- Detects the halt instruction (WFI) and stops retirement.

Parameters:
- XLEN, 32, data/address width.
- TAG_LEN, `ROB_TAG_LEN, ROB tag width.
- HALT_INST, 32'h10500073, encoding that halts retirement.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- head_entry  input  ROB_ENTRY  current ROB head (valid, NPC, inst, wr_mem, dest_reg, dest_addr, value, mem_size, ...).
- head  input  TAG_LEN  tag of the head entry.
- head_ready  input  1  head value_ready && address_ready.
- rob_retire  output  1  one-cycle pulse; ROB advances head and clears the entry at this edge.
- rf_wr_en  output  1  register-file write enable.
- rf_wr_idx  output  5  destination register.
- rf_wr_data  output  XLEN  write data.
- rf_wr_tag  output  TAG_LEN  retiring tag; the map table clears its entry if the tag matches.
- mem_req  output  1  store request, held until acknowledged.
- mem_addr  output  XLEN  store address.
- mem_data  output  XLEN  store data.
- mem_size  output  3  store size (MEM_SIZE encoding).
- mem_ack  input  1  memory accepted the store this cycle.
- commit_npc  output  XLEN  NPC of the last retired instruction.
- halt  output  1  sticky; set once HALT_INST retires.

Behaviour:
- FSM states:
  - IDLE: retire candidate.
  - STORE: store outstanding.
  - HALTED: terminal.
- Reset (async, reset==0):
  - state=IDLE; store latches=0; commit_npc=0; halt=0.
  - All outputs 0, including mem_req; mem_req drops immediately even mid-store.
- Retirement condition: retire only if head_entry.valid && head_ready.
- IDLE, non-store ready, inst != HALT_INST:
  - rob_retire=1 combinationally in the same cycle.
  - rf_wr_en=1 unless dest_reg==0; rf_wr_idx=dest_reg; rf_wr_data=value; rf_wr_tag=head.
  - commit_npc<=NPC at the edge; stay in IDLE.
  - Back-to-back: one retire per cycle maximum.
- IDLE, store ready (wr_mem=1):
  - No retire this cycle.
  - At the edge latch dest_addr, value, mem_size and head tag; go to STORE.
- STORE:
  - mem_req=1 from a register; mem_addr/data/size come from the latches and are stable while mem_req=1.
  - rf_wr_en=0.
  - On mem_ack=1: rob_retire=1 that cycle; commit_npc<=NPC; return to IDLE; mem_req is 0 the following cycle.
  - Minimum store latency: 1 cycle (mem_ack may rise the first cycle mem_req is high).
  - If mem_ack=0, wait indefinitely.
  - head_entry changes while in STORE are ignored.
- IDLE, HALT_INST ready:
  - rob_retire=1; no register write; commit_npc<=NPC.
  - halt<=1; go to HALTED.
- HALTED: no retire, no requests, halt stays 1 until reset.
- head_ready=1 with head_entry.valid=0: nothing retires.
- mem_ack while not in STORE: ignored.
- Map-table semantics: rf_wr_tag is valid only while rf_wr_en=1.

Optional Feature:
- COMMIT_STATS_EN defined adds two outputs:
  - retired_count, 32-bit output: increments on each rob_retire and wraps at 2^32.
  - store_stall_cycles, 32-bit output: counts cycles in STORE with mem_ack=0, saturating at all-ones.
  - Both counters reset to 0.
- Without the macro, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- ALU retire: head {valid=1, dest_reg=5, value=32'hDEAD_BEEF, NPC=32'h104}, head_ready=1, head=2 -> same cycle rob_retire=1, rf_wr_en=1, rf_wr_idx=5, rf_wr_data=32'hDEADBEEF, rf_wr_tag=2; next cycle commit_npc=32'h104.
- x0 destination: dest_reg=0, ready -> rob_retire=1, rf_wr_en=0.
- Store with 3-cycle ack: head store {dest_addr=32'h100, value=32'h55, mem_size=WORD} ready.
  - Cycle 0: rob_retire=0.
  - Cycles 1-3: mem_req=1, addr=32'h100, data=32'h55; head_entry is changed during cycles 1-3 and the outputs stay stable.
  - mem_ack at cycle 3 -> rob_retire=1 at cycle 3; mem_req=0 at cycle 4.
  - With COMMIT_STATS_EN: store_stall_cycles=2.
- Stream: 4 ready ALU heads in consecutive cycles -> 4 consecutive rob_retire pulses; retired_count=4 with COMMIT_STATS_EN.
- Halt: HALT_INST ready -> rob_retire=1 once, halt=1; a subsequent ready head -> rob_retire stays 0 for 10 cycles.
- Reset mid-store: reset=0 asynchronously while mem_req=1 -> mem_req=0 before the next edge, state IDLE, halt=0.
